// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the solver RAM arbiter: FSM states, owner identity and default bus widths.
package ram_port_arbiter_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH    = 64;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANT_IO     = 2'd1,
        GRANT_SOLVER = 2'd2,
        HANDOVER     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IO     = 1'b0,
        OWNER_SOLVER = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter_hold_timer.sv
// Counts contended grant cycles; terminal marks the last cycle an owner may keep the RAM.
module arbiter_hold_timer #(
    parameter int MAX_HOLD   = 256,
    parameter int HOLD_WIDTH = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam bit                  HOLD_ENABLED   = (MAX_HOLD != 0);
    localparam logic [HOLD_WIDTH-1:0] TERMINAL_COUNT =
        HOLD_ENABLED ? HOLD_WIDTH'(MAX_HOLD - 1) : '0;

    logic [HOLD_WIDTH-1:0] hold_count;

    // Saturates so a long uncontested-limit grant (MAX_HOLD = 0) never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_count <= '0;
        end else if (clear) begin
            hold_count <= '0;
        end else if (enable && (hold_count != {HOLD_WIDTH{1'b1}})) begin
            hold_count <= hold_count + 1'b1;
        end
    end

    assign terminal = HOLD_ENABLED && (hold_count == TERMINAL_COUNT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Grants the shared solver RAM to the IO side or the solver core, one owner at a time,
// with round-robin on contention, optional hold-time preemption and a one-cycle handover gap.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int MAX_HOLD      = 256,
    parameter int HOLD_WIDTH    = 9
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IO_Req,
    input  logic                     IO_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_WR,
    input  logic [DATA_WIDTH-1:0]    IO_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_B,
    input  logic                     Solver_Req,
    input  logic                     Solver_WR_Enable,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_WR,
    input  logic [DATA_WIDTH-1:0]    Solver_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_B,
    output logic                     IO_Grant,
    output logic                     Solver_Grant,
    output logic                     Preempted,
    output logic                     Write_Violation,
    output logic                     RAM_WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
    output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B
);

    arb_state_t state_q, state_d;
    owner_t     last_owner_q, last_owner_d;
    logic       write_violation_q;
    logic       hold_clear, hold_enable, hold_terminal;
    logic       preempt;

    arbiter_hold_timer #(
        .MAX_HOLD   (MAX_HOLD),
        .HOLD_WIDTH (HOLD_WIDTH)
    ) u_hold_timer (
        .clk      (CLK),
        .rst      (RST),
        .clear    (hold_clear),
        .enable   (hold_enable),
        .terminal (hold_terminal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_SOLVER;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // A voluntary release takes priority over preemption when both land in the same cycle.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        preempt      = 1'b0;
        hold_clear   = 1'b1;
        hold_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (IO_Req && Solver_Req) begin
                    state_d = (last_owner_q == OWNER_SOLVER) ? GRANT_IO : GRANT_SOLVER;
                end else if (IO_Req) begin
                    state_d = GRANT_IO;
                end else if (Solver_Req) begin
                    state_d = GRANT_SOLVER;
                end
            end
            GRANT_IO: begin
                hold_clear  = 1'b0;
                hold_enable = Solver_Req;
                if (!IO_Req) begin
                    state_d      = HANDOVER;
                    last_owner_d = OWNER_IO;
                end else if (Solver_Req && hold_terminal) begin
                    state_d      = HANDOVER;
                    last_owner_d = OWNER_IO;
                    preempt      = 1'b1;
                end
            end
            GRANT_SOLVER: begin
                hold_clear  = 1'b0;
                hold_enable = IO_Req;
                if (!Solver_Req) begin
                    state_d      = HANDOVER;
                    last_owner_d = OWNER_SOLVER;
                end else if (IO_Req && hold_terminal) begin
                    state_d      = HANDOVER;
                    last_owner_d = OWNER_SOLVER;
                    preempt      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign IO_Grant     = (state_q == GRANT_IO);
    assign Solver_Grant = (state_q == GRANT_SOLVER);
    assign Preempted    = preempt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            write_violation_q <= 1'b0;
        end else if ((IO_WR_Enable && !IO_Grant) || (Solver_WR_Enable && !Solver_Grant)) begin
            write_violation_q <= 1'b1;
        end
    end

    assign Write_Violation = write_violation_q;

    // Driven from registered state only, so reset forces the RAM pins to zero at once.
    always_comb begin
        RAM_WR_Enable    = 1'b0;
        RAM_Address_WR   = '0;
        RAM_Data_WR      = '0;
        RAM_Address_RD_A = '0;
        RAM_Address_RD_B = '0;
        case (state_q)
            GRANT_IO: begin
                RAM_WR_Enable    = IO_WR_Enable;
                RAM_Address_WR   = IO_Address_WR;
                RAM_Data_WR      = IO_Data_WR;
                RAM_Address_RD_A = IO_Address_RD_A;
                RAM_Address_RD_B = IO_Address_RD_B;
            end
            GRANT_SOLVER: begin
                RAM_WR_Enable    = Solver_WR_Enable;
                RAM_Address_WR   = Solver_Address_WR;
                RAM_Data_WR      = Solver_Data_WR;
                RAM_Address_RD_A = Solver_Address_RD_A;
                RAM_Address_RD_B = Solver_Address_RD_B;
            end
            default: begin
            end
        endcase
    end

endmodule
